// File: rtl/dpbram_fifo_pkg.sv
// Shared types and width helpers for the dual-port-BRAM FIFO controller.
// Width helpers take the instance's ADDR_WIDTH because it is a module parameter.
package dpbram_fifo_pkg;

  localparam int BUF_DEPTH = 2;

  // Output buffer occupancy; the encoding equals the number of held words.
  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_t;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic int lvl_width(input int addr_width);
    return addr_width + 2;
  endfunction

  function automatic logic [1:0] buf_count(input buf_state_t s);
    return 2'(s);
  endfunction

endpackage

// File: rtl/dpbram_fifo_outbuf.sv
// Two-entry capture/skid buffer that absorbs the BRAM's one-cycle read latency.
// The head register drives m_data; state is exported so the parent can see occupancy.
module dpbram_fifo_outbuf
  import dpbram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  fill,
  input  logic [DATA_WIDTH-1:0] fill_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output buf_state_t            state
);

  buf_state_t            state_next;
  logic                  pop;
  logic                  load_head;
  logic                  load_skid;
  logic                  shift;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] skid_q;

  assign m_valid = (state != BUF_EMPTY);
  assign m_data  = head_q;
  assign pop     = m_valid & m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BUF_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // The parent never issues a fetch that could land while both entries are
  // held, so a fill only arrives in EMPTY or ONE.
  always_comb begin
    state_next = state;
    load_head  = 1'b0;
    load_skid  = 1'b0;
    shift      = 1'b0;
    if (flush) begin
      state_next = BUF_EMPTY;
    end else begin
      case (state)
        BUF_EMPTY: begin
          if (fill) begin
            load_head  = 1'b1;
            state_next = BUF_ONE;
          end
        end
        BUF_ONE: begin
          case ({fill, pop})
            2'b10: begin
              load_skid  = 1'b1;
              state_next = BUF_TWO;
            end
            2'b11: load_head = 1'b1;
            2'b01: state_next = BUF_EMPTY;
            default: ;
          endcase
        end
        BUF_TWO: begin
          if (pop) begin
            shift      = 1'b1;
            state_next = BUF_ONE;
          end
        end
        default: state_next = BUF_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_head) begin
        head_q <= fill_data;
      end else if (shift) begin
        head_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= fill_data;
      end
    end
  end

endmodule

// File: rtl/dpbram_fifo_ctrl.sv
// First-word-fall-through FIFO sequencer around an external simple dual-port BRAM
// (write port A, registered read port B with one cycle of latency).
module dpbram_fifo_ctrl
  import dpbram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int MEM_DEPTH  = 1 << ADDR_WIDTH
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_flush,
  input  logic                              i_s_valid,
  output logic                              o_s_ready,
  input  logic [DATA_WIDTH-1:0]             i_s_data,
  output logic                              o_m_valid,
  input  logic                              i_m_ready,
  output logic [DATA_WIDTH-1:0]             o_m_data,
  output logic [lvl_width(ADDR_WIDTH)-1:0]  o_level,
  output logic                              o_ram_enA,
  output logic                              o_ram_weA,
  output logic [ADDR_WIDTH-1:0]             o_ram_addrA,
  output logic [DATA_WIDTH-1:0]             o_ram_dinA,
  output logic                              o_ram_enB,
  output logic [ADDR_WIDTH-1:0]             o_ram_addrB,
  input  logic [DATA_WIDTH-1:0]             i_ram_doutB
);

  localparam int PTR_W = ptr_width(ADDR_WIDTH);
  localparam int LVL_W = lvl_width(ADDR_WIDTH);

  // Handshakes: a word moves on a rising edge where valid & ready are both high;
  // valid and data hold until accepted, and i_flush cancels any transfer that cycle.

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] ram_count;
  logic             ram_full;
  logic             rd_pend;
  logic             rst_done;
  logic             push;
  logic             pop;
  logic             fetch;
  buf_state_t       buf_state;
  logic [1:0]       n_buf;
  logic [2:0]       buf_demand;
  logic [LVL_W-1:0] level_q;
  logic [LVL_W-1:0] level_next;

  assign ram_count = wr_ptr - rd_ptr;
  assign ram_full  = (ram_count == PTR_W'(MEM_DEPTH));
  assign n_buf     = buf_count(buf_state);

  assign o_s_ready = rst_done & ~ram_full;
  assign push      = i_s_valid & o_s_ready & ~i_flush;
  assign pop       = o_m_valid & i_m_ready;

  // Words the buffer must hold after this edge if nothing new is fetched;
  // a fetch is only issued when its return is guaranteed a free entry.
  assign buf_demand = {1'b0, n_buf} + {2'b00, rd_pend} - {2'b00, pop};
  assign fetch      = (ram_count != '0) & (buf_demand < 3'(BUF_DEPTH)) & ~i_flush;

  assign o_ram_enA   = push;
  assign o_ram_weA   = push;
  assign o_ram_addrA = wr_ptr[ADDR_WIDTH-1:0];
  assign o_ram_dinA  = i_s_data;
  assign o_ram_enB   = fetch;
  assign o_ram_addrB = rd_ptr[ADDR_WIDTH-1:0];

  // A fetch moves a word from RAM to in-flight without changing the total.
  assign level_next = LVL_W'(ram_count) + LVL_W'(n_buf) + LVL_W'(rd_pend)
                    + LVL_W'(push) - LVL_W'(pop);
  assign o_level    = level_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_pend  <= 1'b0;
      rst_done <= 1'b0;
      level_q  <= '0;
    end else begin
      rst_done <= 1'b1;
      if (i_flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        rd_pend <= 1'b0;
        level_q <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (fetch) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        rd_pend <= fetch;
        level_q <= level_next;
      end
    end
  end

  dpbram_fifo_outbuf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_outbuf (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .flush    (i_flush),
    .fill     (rd_pend),
    .fill_data(i_ram_doutB),
    .m_valid  (o_m_valid),
    .m_ready  (i_m_ready),
    .m_data   (o_m_data),
    .state    (buf_state)
  );

endmodule

// File: tb/tb_dpbram_fifo_ctrl.sv
// Bench for dpbram_fifo_ctrl with a small BRAM model, a FIFO-order scoreboard
// and an occupancy model (accepted minus delivered words).
module tb_dpbram_fifo_ctrl;

  localparam int DW  = 32;
  localparam int AW  = 2;
  localparam int LW  = AW + 2;
  localparam int CAP = (1 << AW) + 2;

  logic          i_clk;
  logic          i_rst_n;
  logic          i_flush;
  logic          i_s_valid;
  logic          o_s_ready;
  logic [DW-1:0] i_s_data;
  logic          o_m_valid;
  logic          i_m_ready;
  logic [DW-1:0] o_m_data;
  logic [LW-1:0] o_level;
  logic          o_ram_enA;
  logic          o_ram_weA;
  logic [AW-1:0] o_ram_addrA;
  logic [DW-1:0] o_ram_dinA;
  logic          o_ram_enB;
  logic [AW-1:0] o_ram_addrB;
  logic [DW-1:0] ram_doutB;

  int checks   = 0;
  int failures = 0;
  int pop_count = 0;
  int model_count = 0;
  logic [DW-1:0] exp_q[$];

  dpbram_fifo_ctrl #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .MEM_DEPTH (1 << AW)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_flush    (i_flush),
    .i_s_valid  (i_s_valid),
    .o_s_ready  (o_s_ready),
    .i_s_data   (i_s_data),
    .o_m_valid  (o_m_valid),
    .i_m_ready  (i_m_ready),
    .o_m_data   (o_m_data),
    .o_level    (o_level),
    .o_ram_enA  (o_ram_enA),
    .o_ram_weA  (o_ram_weA),
    .o_ram_addrA(o_ram_addrA),
    .o_ram_dinA (o_ram_dinA),
    .o_ram_enB  (o_ram_enB),
    .o_ram_addrB(o_ram_addrB),
    .i_ram_doutB(ram_doutB)
  );

  // Clock and BRAM model
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic [DW-1:0] bram [0:(1<<AW)-1];
  always @(posedge i_clk) begin
    if (o_ram_enA && o_ram_weA) bram[o_ram_addrA] <= o_ram_dinA;
    if (o_ram_enB) ram_doutB <= bram[o_ram_addrB];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Input-side recorder: accepted words enter the expected queue; occupancy model
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      exp_q.delete();
      model_count = 0;
    end else begin
      check("level_model", 64'(o_level), 64'(model_count));
      if (i_flush) begin
        exp_q.delete();
        model_count = 0;
      end else begin
        if (i_s_valid && o_s_ready) begin
          exp_q.push_back(i_s_data);
          model_count++;
        end
        if (o_m_valid && i_m_ready) model_count--;
        if (model_count > CAP) check("capacity", 64'(model_count), 64'(CAP));
      end
    end
  end

  // Output monitor: compares delivered words and checks hold stability
  logic          prev_hold = 1'b0;
  logic [DW-1:0] prev_data = '0;
  always @(negedge i_clk) begin
    if (!i_rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 64'(o_m_valid), 64'd1);
        check("hold_data", 64'(o_m_data), 64'(prev_data));
      end
      if (!i_flush && o_m_valid && i_m_ready) begin
        pop_count++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word actual=%0h expected=none", o_m_data);
        end else begin
          check("m_data", 64'(o_m_data), 64'(exp_q.pop_front()));
        end
      end
      prev_hold = o_m_valid && !i_m_ready && !i_flush;
      prev_data = o_m_data;
    end
  end

  task automatic drain(input string name);
    i_s_valid = 1'b0;
    i_m_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge i_clk);
      if (!o_m_valid && o_level == '0) break;
      tick();
    end
    check(name, {63'(o_level), o_m_valid}, 64'd0);
    check({name, "_queue"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  int base_pops;
  logic lvl_ok;

  initial begin
    i_rst_n = 1'b0; i_flush = 1'b0; i_s_valid = 1'b0; i_s_data = '0; i_m_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    #1;
    check("rst_s_ready", 64'(o_s_ready), 64'd0);
    check("rst_m_valid", 64'(o_m_valid), 64'd0);
    check("rst_level", 64'(o_level), 64'd0);
    check("rst_m_data", 64'(o_m_data), 64'd0);
    tick();
    check("rst_done_ready", 64'(o_s_ready), 64'd1);

    // T1: single word latency
    i_m_ready = 1'b1;
    i_s_valid = 1'b1; i_s_data = 32'hA5A50001;
    @(negedge i_clk);
    check("t1_enA", 64'(o_ram_enA), 64'd1);
    check("t1_weA", 64'(o_ram_weA), 64'd1);
    check("t1_addrA", 64'(o_ram_addrA), 64'd0);
    check("t1_dinA", 64'(o_ram_dinA), 64'hA5A50001);
    tick(); i_s_valid = 1'b0;
    @(negedge i_clk);
    check("t1_level_t1", 64'(o_level), 64'd1);
    check("t1_enB_t1", 64'(o_ram_enB), 64'd1);
    check("t1_valid_t1", 64'(o_m_valid), 64'd0);
    tick();
    @(negedge i_clk);
    check("t1_valid_t2", 64'(o_m_valid), 64'd0);
    tick();
    @(negedge i_clk);
    check("t1_valid_t3", 64'(o_m_valid), 64'd1);
    check("t1_data_t3", 64'(o_m_data), 64'hA5A50001);
    check("t1_level_t3", 64'(o_level), 64'd1);
    tick();
    @(negedge i_clk);
    check("t1_valid_t4", 64'(o_m_valid), 64'd0);
    check("t1_level_t4", 64'(o_level), 64'd0);

    // T2: fill to capacity with the consumer stalled
    tick();
    i_m_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      i_s_valid = 1'b1; i_s_data = 32'(k);
      @(negedge i_clk);
      check("t2_s_ready", 64'(o_s_ready), 64'(k < CAP));
      tick();
    end
    i_s_valid = 1'b0;
    @(negedge i_clk);
    check("t2_level_full", 64'(o_level), 64'(CAP));
    tick();
    base_pops = pop_count;
    drain("t2_drain");
    check("t2_pops", 64'(pop_count - base_pops), 64'(CAP));

    // T3: streaming at one word per clock
    tick();
    base_pops = pop_count;
    i_m_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      i_s_valid = 1'b1; i_s_data = 32'h3000_0000 + 32'(i);
      @(negedge i_clk);
      check("t3_s_ready", 64'(o_s_ready), 64'd1);
      if (i >= 3) begin
        check("t3_m_valid", 64'(o_m_valid), 64'd1);
        lvl_ok = (o_level == LW'(2)) || (o_level == LW'(3));
        check("t3_level", 64'(lvl_ok), 64'd1);
      end
      tick();
    end
    drain("t3_drain");
    check("t3_pops", 64'(pop_count - base_pops), 64'd200);

    // T4: random traffic
    tick();
    for (int i = 0; i < 800; i++) begin
      i_s_valid = ($urandom_range(0, 3) != 0);
      i_s_data  = $urandom();
      i_m_ready = (i < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      tick();
    end
    drain("t4_drain");

    // T5: flush while a read is in flight
    tick();
    i_m_ready = 1'b0;
    i_s_valid = 1'b1; i_s_data = 32'h11;
    tick();
    i_s_data = 32'h22;
    @(negedge i_clk);
    check("t5_fetch", 64'(o_ram_enB), 64'd1);
    tick();
    i_s_valid = 1'b0; i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    @(negedge i_clk);
    check("t5_valid", 64'(o_m_valid), 64'd0);
    check("t5_level", 64'(o_level), 64'd0);
    check("t5_s_ready", 64'(o_s_ready), 64'd1);
    base_pops = pop_count;
    i_m_ready = 1'b1; i_s_valid = 1'b1; i_s_data = 32'h55;
    tick();
    drain("t5_drain");
    check("t5_pops", 64'(pop_count - base_pops), 64'd1);

    // T6: asynchronous reset mid-stream
    tick();
    i_m_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      i_s_valid = 1'b1; i_s_data = 32'h6000_0000 + 32'(k);
      tick();
    end
    i_s_valid = 1'b0;
    @(negedge i_clk);
    check("t6_valid_before", 64'(o_m_valid), 64'd1);
    @(posedge i_clk);
    #3 i_rst_n = 1'b0;
    #1;
    check("t6_valid_rst", 64'(o_m_valid), 64'd0);
    check("t6_ready_rst", 64'(o_s_ready), 64'd0);
    check("t6_level_rst", 64'(o_level), 64'd0);
    check("t6_data_rst", 64'(o_m_data), 64'd0);
    @(negedge i_clk);
    @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    #1;
    check("t6_ready_release", 64'(o_s_ready), 64'd0);
    tick();
    check("t6_ready_after", 64'(o_s_ready), 64'd1);
    base_pops = pop_count;
    i_m_ready = 1'b1; i_s_valid = 1'b1; i_s_data = 32'h77;
    tick();
    drain("t6_drain");
    check("t6_pops", 64'(pop_count - base_pops), 64'd1);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
